// File: rtl/shift_byte_collector.sv
// Frame collector: counts shift strobes, captures the parallel word per frame into a small FIFO.
// Optional macro CAPTURE_PARITY_EN stores an even-parity bit with each captured word.
module shift_byte_collector #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 8,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     shift_valid,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     clr_ovf,
  output logic                     m_valid,
  output logic [WIDTH-1:0]         m_data,
  output logic                     m_parity,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               bit_count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
`ifdef CAPTURE_PARITY_EN
  localparam int EW = WIDTH + 1;
`else
  localparam int EW = WIDTH;
`endif
  localparam logic [7:0]    LAST_BIT_C = 8'(FRAME_LEN - 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C      = CW'(1);
  localparam logic [CW-1:0] ZERO_C     = CW'(0);

  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  logic [7:0]    bit_count_r;
  logic          capture_pending_r;
  logic [EW-1:0] mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          m_valid_r;
  logic          overflow_r;

  logic          pop_s;
  logic          accept_s;
  logic          drop_s;
  logic [CW-1:0] count_next_s;
  logic [EW-1:0] wr_entry_s;

  // Push/pop qualification and next occupancy
  always_comb begin
    pop_s        = m_valid_r & m_ready;
    accept_s     = 1'b0;
    drop_s       = 1'b0;
    count_next_s = count_r;
    if (capture_pending_r) begin
      accept_s = (count_r != DEPTH_C) | pop_s;
      drop_s   = ~accept_s;
    end else begin
      accept_s = 1'b0;
      drop_s   = 1'b0;
    end
    case ({accept_s, pop_s})
      2'b10:   count_next_s = count_r + ONE_C;
      2'b01:   count_next_s = count_r - ONE_C;
      default: count_next_s = count_r;
    endcase
  end

  // Entry formatting; parity is computed once at capture time
  always_comb begin
`ifdef CAPTURE_PARITY_EN
    wr_entry_s = {even_parity(data_in), data_in};
`else
    wr_entry_s = data_in;
`endif
  end

  // Frame bit counter and one-cycle capture request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_count_r       <= 8'd0;
      capture_pending_r <= 1'b0;
    end else if (shift_valid) begin
      if (bit_count_r == LAST_BIT_C) begin
        bit_count_r       <= 8'd0;
        capture_pending_r <= 1'b1;
      end else begin
        bit_count_r       <= bit_count_r + 8'd1;
        capture_pending_r <= 1'b0;
      end
    end else begin
      capture_pending_r <= 1'b0;
    end
  end

  // FIFO storage, pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= ZERO_C;
      m_valid_r  <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (accept_s) begin
        mem_r[wr_ptr_r] <= wr_entry_s;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + 1'b1;
      count_r   <= count_next_s;
      m_valid_r <= (count_next_s != ZERO_C);
      // A drop in the same cycle as a clear keeps the flag set
      if (drop_s)       overflow_r <= 1'b1;
      else if (clr_ovf) overflow_r <= 1'b0;
      else              overflow_r <= overflow_r;
    end
  end

  assign m_valid    = m_valid_r;
  assign m_data     = mem_r[rd_ptr_r][WIDTH-1:0];
`ifdef CAPTURE_PARITY_EN
  assign m_parity   = mem_r[rd_ptr_r][WIDTH];
`else
  assign m_parity   = 1'b0;
`endif
  assign fifo_count = count_r;
  assign bit_count  = bit_count_r;
  assign overflow   = overflow_r;

endmodule
